// File: rtl/beta_regfile_sb.sv
// ============================================================================
// Module  : beta_regfile_sb
// Brief   : 2R/1W register file with hardwired zero register, optional
//           write-back bypass and a per-register write-pending scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module beta_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rc,
  input  logic              ra2sel,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rc,
  input  logic              werf,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic              hazard1,
  output logic              hazard2,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int                NREG   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(ZERO_REG);
  localparam logic              C_BYP  = (BYPASS != 0);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  logic [ADDR_W-1:0] w_ra2;
  logic              w_fwd1;
  logic              w_fwd2;
  logic              w_issue;
  logic              w_inc;
  logic              w_dec;

  assign w_ra2  = ra2sel ? rc : rb;
  assign w_fwd1 = C_BYP && werf && (wa == ra);
  assign w_fwd2 = C_BYP && werf && (wa == w_ra2);

  always_comb begin
    rd1 = '0;
    if (ra != C_ZERO) rd1 = w_fwd1 ? wd : mem_q[ra];
  end

  always_comb begin
    rd2 = '0;
    if (w_ra2 != C_ZERO) rd2 = w_fwd2 ? wd : mem_q[w_ra2];
  end

  assign hazard1  = (ra != C_ZERO) && busy_q[ra] && !w_fwd1;
  assign hazard2  = (w_ra2 != C_ZERO) && busy_q[w_ra2] && !w_fwd2;
  assign busy_cnt = cnt_q;

  // Set after clear: a newer producer to the same register stays outstanding.
  assign w_issue = issue_valid && (issue_rc != C_ZERO);
  assign w_inc   = w_issue && !busy_q[issue_rc];
  assign w_dec   = werf && busy_q[wa] && !(w_issue && (issue_rc == wa));

  always_comb begin
    busy_d = busy_q;
    if (werf)    busy_d[wa]       = 1'b0;
    if (w_issue) busy_d[issue_rc] = 1'b1;
    busy_d[C_ZERO] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_inc && !w_dec) cnt_d = cnt_q + 1'b1;
    if (w_dec && !w_inc) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (werf && (wa != C_ZERO)) mem_q[wa] <= wd;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_beta_regfile_sb.sv
// ============================================================================
// Module  : tb_beta_regfile_sb
// Brief   : Directed vector bench for beta_regfile_sb (bypass and no-bypass).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beta_regfile_sb;

  logic        clk;
  logic        reset;
  logic [4:0]  ra, rb, rc, issue_rc, wa;
  logic        ra2sel, issue_valid, werf;
  logic [31:0] wd;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        hazard1, hazard2, nb_h1, nb_h2;
  logic [5:0]  busy_cnt, nb_cnt;

  int n_cmp;
  int n_err;

  beta_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(31), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .ra(ra), .rb(rb), .rc(rc), .ra2sel(ra2sel),
    .rd1(rd1), .rd2(rd2), .issue_valid(issue_valid), .issue_rc(issue_rc),
    .werf(werf), .wa(wa), .wd(wd), .hazard1(hazard1), .hazard2(hazard2),
    .busy_cnt(busy_cnt)
  );

  beta_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(31), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .ra(ra), .rb(rb), .rc(rc), .ra2sel(ra2sel),
    .rd1(nb_rd1), .rd2(nb_rd2), .issue_valid(issue_valid), .issue_rc(issue_rc),
    .werf(werf), .wa(wa), .wd(wd), .hazard1(nb_h1), .hazard2(nb_h2),
    .busy_cnt(nb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra, rb, rc;
    logic        sel, iv;
    logic [4:0]  irc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_rd1, e_rd2;
    logic        e_h1, e_h2;
    logic [5:0]  e_cnt;
    logic [31:0] e_nb1;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic s, input logic iv, input logic [4:0] irc,
                       input logic we, input logic [4:0] w, input logic [31:0] d);
    ra = a; rb = b; rc = c; ra2sel = s;
    issue_valid = iv; issue_rc = irc; werf = we; wa = w; wd = d;
  endtask

  task automatic set_vec(input int i, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic s, input logic iv,
                         input logic [4:0] irc, input logic we, input logic [4:0] w,
                         input logic [31:0] d, input logic [31:0] r1, input logic [31:0] r2,
                         input logic h1, input logic h2, input logic [5:0] cnt,
                         input logic [31:0] nb1);
    vt[i] = '{ra: a, rb: b, rc: c, sel: s, iv: iv, irc: irc, we: we, wa: w, wd: d,
              e_rd1: r1, e_rd2: r2, e_h1: h1, e_h2: h2, e_cnt: cnt, e_nb1: nb1};
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    //       ra  rb  rc s iv irc we wa  wd            rd1           rd2           h1 h2 cnt nb_rd1
    set_vec( 0,  5,  0,  0, 0, 0, 0,  1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h0);
    set_vec( 1,  5,  0,  0, 0, 0, 0,  0, 0, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0, 0, 32'hDEADBEEF);
    set_vec( 2, 31,  5,  0, 0, 0, 0,  1, 2, 32'hA,        32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h0);
    set_vec( 3,  2,  2,  9, 0, 0, 0,  1, 9, 32'hB,        32'hA,        32'hA,        0, 0, 0, 32'hA);
    set_vec( 4,  2,  2,  9, 1, 0, 0,  0, 0, 32'h0,        32'hA,        32'hB,        0, 0, 0, 32'hA);
    set_vec( 5, 31, 31,  0, 0, 1, 31, 1, 31, 32'h1234,    32'h0,        32'h0,        0, 0, 0, 32'h0);
    set_vec( 6, 31, 31,  0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0);
    set_vec( 7,  4,  4,  0, 0, 1, 4,  0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0);
    set_vec( 8,  4,  4,  0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 1, 32'h0);
    set_vec( 9,  4,  4,  0, 0, 0, 0,  1, 4, 32'h44,       32'h44,       32'h44,       0, 0, 1, 32'h0);
    set_vec(10,  4,  4,  0, 0, 0, 0,  0, 0, 32'h0,        32'h44,       32'h44,       0, 0, 0, 32'h44);
    set_vec(11,  4,  4,  0, 0, 1, 4,  0, 0, 32'h0,        32'h44,       32'h44,       0, 0, 0, 32'h44);
    set_vec(12,  4,  4,  0, 0, 1, 4,  1, 4, 32'h55,       32'h55,       32'h55,       0, 0, 1, 32'h44);
    set_vec(13,  4,  4,  0, 0, 0, 0,  0, 0, 32'h0,        32'h55,       32'h55,       1, 1, 1, 32'h55);
    set_vec(14,  4,  6,  0, 0, 1, 6,  0, 0, 32'h0,        32'h55,       32'h0,        1, 0, 1, 32'h55);
    set_vec(15,  4,  6,  0, 0, 0, 0,  0, 0, 32'h0,        32'h55,       32'h0,        1, 1, 2, 32'h55);
    set_vec(16,  4,  6,  0, 0, 1, 6,  1, 4, 32'h66,       32'h66,       32'h0,        0, 1, 2, 32'h55);
    set_vec(17,  4,  6,  0, 0, 0, 0,  0, 0, 32'h0,        32'h66,       32'h0,        0, 1, 1, 32'h66);
    set_vec(18,  7,  6,  0, 0, 0, 0,  1, 7, 32'h77,       32'h77,       32'h0,        0, 1, 1, 32'h0);
    set_vec(19,  7,  6,  0, 0, 0, 0,  0, 0, 32'h0,        32'h77,       32'h0,        0, 1, 1, 32'h77);
    set_vec(20,  7,  6,  0, 0, 0, 0,  1, 6, 32'h60,       32'h77,       32'h60,       0, 0, 1, 32'h77);
    set_vec(21,  7,  6,  0, 0, 0, 0,  0, 0, 32'h0,        32'h77,       32'h60,       0, 0, 0, 32'h77);

    // Reset held across an edge with an issue request that must be ignored.
    reset = 1'b1;
    drive(3, 7, 0, 0, 1, 3, 1, 3, 32'h99);
    @(negedge clk);
    drive(3, 7, 0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_rd2", rd2, 32'h0);
    chk("rst_h1", {31'b0, hazard1}, 32'h0);
    chk("rst_h2", {31'b0, hazard2}, 32'h0);
    chk("rst_cnt", {26'b0, busy_cnt}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vt[i].ra, vt[i].rb, vt[i].rc, vt[i].sel, vt[i].iv, vt[i].irc,
            vt[i].we, vt[i].wa, vt[i].wd);
      #2;
      chk($sformatf("v%0d_rd1", i), rd1, vt[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), rd2, vt[i].e_rd2);
      chk($sformatf("v%0d_h1", i), {31'b0, hazard1}, {31'b0, vt[i].e_h1});
      chk($sformatf("v%0d_h2", i), {31'b0, hazard2}, {31'b0, vt[i].e_h2});
      chk($sformatf("v%0d_cnt", i), {26'b0, busy_cnt}, {26'b0, vt[i].e_cnt});
      chk($sformatf("v%0d_nb_rd1", i), nb_rd1, vt[i].e_nb1);
    end

    // Async reset mid-cycle with three registers pending.
    for (int r = 1; r <= 3; r++) begin
      @(negedge clk);
      drive(5, 0, 0, 0, 1, 5'(r), 0, 0, 32'h0);
    end
    @(negedge clk);
    drive(1, 2, 3, 1, 0, 0, 0, 0, 32'h0);
    #2;
    chk("pre_cnt", {26'b0, busy_cnt}, 32'd3);
    chk("pre_h1", {31'b0, hazard1}, 32'h1);
    chk("pre_h2", {31'b0, hazard2}, 32'h1);
    ra = 5'd7;
    #1;
    chk("pre_rd1", rd1, 32'h77);
    ra = 5'd1;
    #1;
    reset = 1'b1;
    #1;
    chk("arst_cnt", {26'b0, busy_cnt}, 32'h0);
    chk("arst_h1", {31'b0, hazard1}, 32'h0);
    chk("arst_h2", {31'b0, hazard2}, 32'h0);
    ra = 5'd7;
    #1;
    chk("arst_rd1", rd1, 32'h0);

    // First edge after deassertion performs a normal write.
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 0, 1, 2, 1, 1, 32'h11);
    @(negedge clk);
    drive(1, 2, 0, 0, 0, 0, 0, 0, 32'h0);
    #2;
    chk("post_nb_rd1", nb_rd1, 32'h11);
    chk("post_h2", {31'b0, hazard2}, 32'h1);
    chk("post_cnt", {26'b0, busy_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
